// File: rtl/axi_xbar_pkg.sv
// Shared types, response codes and the address decoder for the AXI read crossbar.
package axi_xbar_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Decoder tables are sized for the largest supported fabric; unused rows are ignored.
  localparam int MAX_S  = 8;
  localparam int MAX_AW = 64;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DFLT} state_e;

  typedef logic [MAX_S-1:0][MAX_AW-1:0] addr_tbl_t;

  // Returns the lowest matching slave index, or n_s when nothing matches.
  function automatic logic [3:0] addr_decode(input logic [MAX_AW-1:0] addr,
                                             input addr_tbl_t         base,
                                             input addr_tbl_t         mask,
                                             input int                n_s);
    logic [3:0] idx;
    idx = 4'(n_s);
    for (int i = MAX_S-1; i >= 0; i--) begin
      if (i < n_s && (addr & mask[i]) == base[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any_req
);

  logic [N-1:0] rot;
  logic         found;
  int           sum;

  always_comb begin
    rot   = N'({req, req} >> ptr);
    grant = '0;
    found = 1'b0;
    sum   = 0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        sum = int'(ptr) + k;
        if (sum >= N) sum = sum - N;
        grant = PW'(sum);
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axi_rd_xbar.sv
// NUM_M x NUM_S AXI read crossbar, one burst in flight, with an internal DECERR slave.
import axi_xbar_pkg::*;

module axi_rd_xbar #(
  parameter int NUM_M  = 2,
  parameter int NUM_S  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 4,
  parameter logic [NUM_S*ADDR_W-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_S*ADDR_W-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
  localparam int IDS_W = ID_W + 4
) (
  input  logic                               ACLK,
  input  logic                               ARESETn,
  input  logic [NUM_M-1:0][ID_W-1:0]         m_arid,
  input  logic [NUM_M-1:0][ADDR_W-1:0]       m_araddr,
  input  logic [NUM_M-1:0][LEN_W-1:0]        m_arlen,
  input  logic [NUM_M-1:0][2:0]              m_arsize,
  input  logic [NUM_M-1:0][1:0]              m_arburst,
  input  logic [NUM_M-1:0]                   m_arvalid,
  output logic [NUM_M-1:0]                   m_arready,
  output logic [NUM_M-1:0][ID_W-1:0]         m_rid,
  output logic [NUM_M-1:0][DATA_W-1:0]       m_rdata,
  output logic [NUM_M-1:0][1:0]              m_rresp,
  output logic [NUM_M-1:0]                   m_rlast,
  output logic [NUM_M-1:0]                   m_rvalid,
  input  logic [NUM_M-1:0]                   m_rready,
  output logic [NUM_S-1:0][IDS_W-1:0]        s_arid,
  output logic [NUM_S-1:0][ADDR_W-1:0]       s_araddr,
  output logic [NUM_S-1:0][LEN_W-1:0]        s_arlen,
  output logic [NUM_S-1:0][2:0]              s_arsize,
  output logic [NUM_S-1:0][1:0]              s_arburst,
  output logic [NUM_S-1:0]                   s_arvalid,
  input  logic [NUM_S-1:0]                   s_arready,
  input  logic [NUM_S-1:0][IDS_W-1:0]        s_rid,
  input  logic [NUM_S-1:0][DATA_W-1:0]       s_rdata,
  input  logic [NUM_S-1:0][1:0]              s_rresp,
  input  logic [NUM_S-1:0]                   s_rlast,
  input  logic [NUM_S-1:0]                   s_rvalid,
  output logic [NUM_S-1:0]                   s_rready
);

  localparam int MW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int SW = (NUM_S > 1) ? $clog2(NUM_S) : 1;

  state_e            state_q, state_d;
  logic [MW-1:0]     grant_q, grant_d;
  logic [MW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [SW-1:0]     tgt_q, tgt_d;
  logic              miss_q, miss_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic [MW-1:0]     arb_grant;
  logic              any_req;
  logic [MW-1:0]     nxt_ptr;
  logic [3:0]        dec;
  addr_tbl_t         base_tbl, mask_tbl;

  // Upper slave-side ID bits carry the grant index and are dropped on the way back.
  logic              unused_rid;
  assign unused_rid = ^s_rid;

  rr_arbiter #(.N(NUM_M), .PW(MW)) u_arb (
    .req     (m_arvalid),
    .ptr     (rr_ptr_q),
    .grant   (arb_grant),
    .any_req (any_req)
  );

  always_comb begin
    base_tbl = '0;
    mask_tbl = '0;
    for (int i = 0; i < NUM_S; i++) begin
      base_tbl[i] = MAX_AW'(SLV_BASE[i*ADDR_W +: ADDR_W]);
      mask_tbl[i] = MAX_AW'(SLV_MASK[i*ADDR_W +: ADDR_W]);
    end
  end

  assign dec     = addr_decode(MAX_AW'(m_araddr[arb_grant]), base_tbl, mask_tbl, NUM_S);
  assign nxt_ptr = (int'(grant_q) == NUM_M-1) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    tgt_d    = tgt_q;
    miss_d   = miss_q;
    cnt_d    = cnt_q;
    id_d     = id_q;

    m_arready = '0;
    m_rid     = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    m_rlast   = '0;
    m_rvalid  = '0;
    s_arid    = '0;
    s_araddr  = '0;
    s_arlen   = '0;
    s_arsize  = '0;
    s_arburst = '0;
    s_arvalid = '0;
    s_rready  = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = arb_grant;
          tgt_d   = SW'(dec);
          miss_d  = (int'(dec) == NUM_S);
          state_d = ADDR;
        end
      end

      ADDR: begin
        if (miss_q) begin
          // Default slave accepts unconditionally; masters hold ARVALID until here.
          m_arready[grant_q] = 1'b1;
          cnt_d   = m_arlen[grant_q];
          id_d    = m_arid[grant_q];
          state_d = DFLT;
        end else begin
          s_arvalid[tgt_q]   = m_arvalid[grant_q];
          s_arid[tgt_q]      = {4'(grant_q), m_arid[grant_q]};
          s_araddr[tgt_q]    = m_araddr[grant_q];
          s_arlen[tgt_q]     = m_arlen[grant_q];
          s_arsize[tgt_q]    = m_arsize[grant_q];
          s_arburst[tgt_q]   = m_arburst[grant_q];
          m_arready[grant_q] = s_arready[tgt_q];
          if (m_arvalid[grant_q] && s_arready[tgt_q]) state_d = DATA;
        end
      end

      DATA: begin
        m_rvalid[grant_q] = s_rvalid[tgt_q];
        m_rid[grant_q]    = s_rid[tgt_q][ID_W-1:0];
        m_rdata[grant_q]  = s_rdata[tgt_q];
        m_rresp[grant_q]  = s_rresp[tgt_q];
        m_rlast[grant_q]  = s_rlast[tgt_q];
        s_rready[tgt_q]   = m_rready[grant_q];
        if (s_rvalid[tgt_q] && m_rready[grant_q] && s_rlast[tgt_q]) begin
          state_d  = IDLE;
          rr_ptr_d = nxt_ptr;
        end
      end

      DFLT: begin
        m_rvalid[grant_q] = 1'b1;
        m_rid[grant_q]    = id_q;
        m_rresp[grant_q]  = RESP_DECERR;
        m_rlast[grant_q]  = (cnt_q == '0);
        if (m_rready[grant_q]) begin
          if (cnt_q == '0) begin
            state_d  = IDLE;
            rr_ptr_d = nxt_ptr;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      tgt_q    <= '0;
      miss_q   <= 1'b0;
      cnt_q    <= '0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      tgt_q    <= tgt_d;
      miss_q   <= miss_d;
      cnt_q    <= cnt_d;
      id_q     <= id_d;
    end
  end

endmodule

// File: doc/axi_rd_xbar.md
# axi_rd_xbar

Parametrised AXI read-path interconnect: NUM_M masters, NUM_S slaves, single outstanding burst at a time. It generalises the fixed 2x2 read bridge with:
- round-robin arbitration over any master count;
- parameter-driven address decode;
- an internal default slave that answers unmapped addresses with DECERR.

It sits between CPU/DMA read masters and memory-side slaves in the bus fabric.

## Interface
- NUM_M, 2, number of masters (1..16)
- NUM_S, 2, number of slaves (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- ID_W, 4, master-side ID width; slave-side ID width IDS_W = ID_W+4 (localparam)
- LEN_W, 4, burst length width
- SLV_BASE, {32'h0001_0000, 32'h0000_0000}, packed NUM_S x ADDR_W base addresses
- SLV_MASK, {32'hFFFF_0000, 32'hFFFF_0000}, packed NUM_S x ADDR_W decode masks
- ACLK  in  1  clock, all logic on rising edge
- ARESETn  in  1  asynchronous, active-low reset
- m_arid/araddr/arlen/arsize/arburst/arvalid  in  [NUM_M] x (ID_W/ADDR_W/LEN_W/3/2/1)  master AR channels
- m_arready  out  [NUM_M]  master AR ready
- m_rid/rdata/rresp/rlast/rvalid  out  [NUM_M] x (ID_W/DATA_W/2/1/1)  master R channels
- m_rready  in  [NUM_M]  master R ready
- s_arid/araddr/arlen/arsize/arburst/arvalid  out  [NUM_S] x (IDS_W/ADDR_W/LEN_W/3/2/1)  slave AR channels
- s_arready  in  [NUM_S]
- s_rid/rdata/rresp/rlast/rvalid  in  [NUM_S] x (IDS_W/DATA_W/2/1/1)
- s_rready  out  [NUM_S]

## Operation
- FSM states: IDLE, ADDR, DATA, DFLT.
- IDLE: if any m_arvalid, grant the first requester at or after rr_ptr (wrapping). Register grant and decode target. Go to ADDR.
- Decode: hit on slave i when (araddr & SLV_MASK[i]) == SLV_BASE[i]. The lowest i wins; no hit selects the default slave.
- ADDR, slave hit: drive s_ar*[tgt] from m_ar*[grant], with s_arid = {4'(grant), m_arid}. m_arready[grant] = s_arready[tgt]. On handshake go to DATA.
- ADDR, miss: m_arready[grant] = 1 for one cycle. Load beat counter with arlen and latch the ID. Go to DFLT.
- DATA: m_r*[grant] = s_r*[tgt], with m_rid = s_rid[ID_W-1:0]. s_rready[tgt] = m_rready[grant]. On rvalid & rready & rlast: go to IDLE and set rr_ptr = (grant+1) mod NUM_M.
- DFLT: m_rvalid = 1, rresp = 2'b11, rdata = 0, rid = latched ID. rlast = 1 when counter == 0. Counter decrements on each handshake. On the last handshake: IDLE, rr_ptr updated as above.
- All non-granted masters and non-target slaves see 0 on every valid/ready output.
- Masters must hold ARVALID until ARREADY (AXI rule). Deasserting early is not supported.

## Timing
- Reset (async assert, sync release): state IDLE, rr_ptr 0, grant 0. Every valid/ready output is 0, all other outputs 0.
- ARVALID sampled at edge t appears on the slave side in cycle t+1. AR latency is 1 cycle plus slave ready delay.
- R path is combinational in DATA: zero added latency, so beat throughput is 1/cycle.
- Default slave: first DECERR beat comes 1 cycle after the AR handshake. arlen = 15 gives exactly 16 beats.
- New arbitration occurs in the IDLE cycle following rlast. Back-to-back bursts therefore cost 2 bubble cycles (IDLE, ADDR).
- Simultaneous requests: resolved by rr_ptr only; requests arriving during a burst wait.
- Reset asserted mid-burst: outputs drop to 0 immediately. An in-flight slave burst is abandoned, and slaves must also be reset.

## Structure
- Package axi_xbar_pkg holds:
  - RESP_OKAY = 2'b00 and RESP_DECERR = 2'b11;
  - the state enum;
  - function addr_decode(addr, base, mask), returning the slave index or NUM_S for a miss.
- Sub-module rr_arbiter (param N): inputs req[N] and ptr. Outputs grant index and any_req. Purely combinational; rr_ptr is held in the parent.

## Test plan
- M0 reads 0x0000_0040, len 3 → s_araddr[0] = 0x40, s_arid[0] = {4'd0, id}. M0 receives 4 beats with rlast on the 4th; rr_ptr = 1.
- M0 and M1 both assert arvalid at reset release → M0 served first, then M1, then M0 again (round-robin alternation over 3 bursts).
- M1 reads 0x0001_0010 with s_arready delayed 3 cycles → m_arready[1] rises only with s_arready[1]; data routed to M1 only.
- M0 reads unmapped 0x8000_0000, len 15 → 16 beats with rresp = 2'b11, rdata 0, rid echoed, rlast on beat 16; no slave sees arvalid.
- m_rready toggled 1,0,0,1 during a slave burst → s_rready mirrors it each cycle; no beat lost or duplicated.
- ARESETn pulsed low during the 2nd beat of a burst → all valids/readies 0 in the same cycle; after release the next request is granted starting from M0.
